// File: rtl/knap_pkg.sv
// Shared constants and helpers for the exhaustive multi-constraint knapsack solver.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package knap_pkg;

    // FSM encoding, kept as plain constants so legacy tools and scripts can decode it
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SEARCH = 2'd1;
    localparam state_t ST_DONE   = 2'd2;

    // Field index 0 of the item table is the value; fields 1..N_DIMS are cost dimensions
    localparam int FIELD_VALUE = 0;

    // Accumulator width that holds the sum of every item at full coefficient scale
    function automatic int sum_width(input int coef_w, input int n_items);
        return coef_w + $clog2(n_items + 1);
    endfunction

    // Count trailing zeros; returns 0 for an all-zero input
    function automatic int ctz(input logic [31:0] x);
        int r;
        r = 0;
        for (int i = 31; i >= 0; i--) begin
            if (x[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/knap_multi_search_if.sv
// Host-side bundle of the solver: table loader, limits, control and result buses.
// Latency: n/a (wiring only).
// Backpressure: none; start is simply ignored while the solver is busy.
interface knap_multi_search_if
    import knap_pkg::*;
#(
    parameter int N_ITEMS = 17,
    parameter int N_DIMS  = 2,
    parameter int COEF_W  = 9,
    parameter int SUM_W   = sum_width(COEF_W, N_ITEMS),
    parameter int CNT_W   = N_ITEMS + 1
);
    logic                          cfg_we;
    logic [$clog2(N_ITEMS)-1:0]    cfg_item;
    logic [$clog2(N_DIMS+1)-1:0]   cfg_field;
    logic [COEF_W-1:0]             cfg_data;
    logic [COEF_W-1:0]             min_value;
    logic [N_DIMS*COEF_W-1:0]      max_cost;
    logic                          start;
    logic                          abort;
    logic                          busy;
    logic                          done;
    logic                          found;
    logic [N_ITEMS-1:0]            best_mask;
    logic [SUM_W-1:0]              best_value;
    logic [CNT_W-1:0]              valid_count;

    modport master (
        output cfg_we, cfg_item, cfg_field, cfg_data, min_value, max_cost, start, abort,
        input  busy, done, found, best_mask, best_value, valid_count
    );

    modport slave (
        input  cfg_we, cfg_item, cfg_field, cfg_data, min_value, max_cost, start, abort,
        output busy, done, found, best_mask, best_value, valid_count
    );
endinterface

// File: rtl/knap_accum.sv
// Add/subtract accumulator tracking one field's sum over the current selection.
// Latency: 1 cycle from en/clr to updated sum.
// Backpressure: none; updates whenever en is high.
module knap_accum #(
    parameter int COEF_W = 9,
    parameter int SUM_W  = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic              sub,
    input  logic [COEF_W-1:0] coef,
    output logic [SUM_W-1:0]  sum
);
    logic [SUM_W-1:0] coef_ext;

    assign coef_ext = SUM_W'(coef);

    // Clear on reset/start, otherwise add or remove the toggled item's coefficient
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            sum <= '0;
        end else if (en) begin
            sum <= sub ? (sum - coef_ext) : (sum + coef_ext);
        end
    end
endmodule

// File: rtl/knap_multi_search.sv
// Exhaustive Gray-order knapsack solver: best-value selection under a value floor and per-dimension limits.
// Latency: start in cycle t, done pulse in cycle t + 2^N_ITEMS + 1.
// Backpressure: none; start ignored while busy, table writes ignored while busy.
module knap_multi_search
    import knap_pkg::*;
#(
    parameter int N_ITEMS = 17,
    parameter int N_DIMS  = 2,
    parameter int COEF_W  = 9,
    parameter int SUM_W   = sum_width(COEF_W, N_ITEMS),
    parameter int CNT_W   = N_ITEMS + 1
) (
    input  logic clk,
    input  logic rst_n,
    knap_multi_search_if.slave bus
);
    localparam int IDX_W    = $clog2(N_ITEMS);
    localparam int N_FIELDS = N_DIMS + 1;

    state_t                   state;
    logic [COEF_W-1:0]        coef_tab [N_FIELDS][N_ITEMS];
    logic [COEF_W-1:0]        min_lat;
    logic [N_DIMS*COEF_W-1:0] cost_lat;
    logic [N_ITEMS-1:0]       step;
    logic [N_ITEMS-1:0]       step_nxt;
    logic [N_ITEMS-1:0]       cur_mask;
    logic [IDX_W-1:0]         flip_idx;
    logic [SUM_W-1:0]         sums [N_FIELDS];
    logic                     last_step;
    logic                     start_go;
    logic                     sum_en;
    logic                     sum_sub;
    logic                     cur_ok;
    logic                     found_r;
    logic [N_ITEMS-1:0]       best_mask_r;
    logic [SUM_W-1:0]         best_value_r;
    logic [CNT_W-1:0]         valid_count_r;

    // Gray stepping: the move from step k to k+1 toggles item ctz(k+1)
    assign step_nxt  = step + N_ITEMS'(1);
    assign flip_idx  = IDX_W'(ctz(32'(step_nxt)));
    assign last_step = &step;
    assign start_go  = (state == ST_IDLE) && bus.start;
    assign sum_en    = (state == ST_SEARCH) && !last_step && !bus.abort;
    assign sum_sub   = cur_mask[flip_idx];

    // One accumulator per field, all stepping on the same toggled item
    for (genvar f = 0; f < N_FIELDS; f++) begin : g_acc
        knap_accum #(
            .COEF_W (COEF_W),
            .SUM_W  (SUM_W)
        ) u_acc (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (start_go),
            .en    (sum_en),
            .sub   (sum_sub),
            .coef  (coef_tab[f][flip_idx]),
            .sum   (sums[f])
        );
    end

    // Current selection is valid when it meets the value floor and every cost limit
    always_comb begin
        cur_ok = (sums[FIELD_VALUE] >= SUM_W'(min_lat));
        for (int d = 0; d < N_DIMS; d++) begin
            if (sums[d+1] > SUM_W'(cost_lat[d*COEF_W +: COEF_W])) cur_ok = 1'b0;
        end
    end

    // Item table: loadable whenever no search is running; out-of-range indices dropped
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int f = 0; f < N_FIELDS; f++) begin
                for (int i = 0; i < N_ITEMS; i++) coef_tab[f][i] <= '0;
            end
        end else if (bus.cfg_we && (state != ST_SEARCH) &&
                     (int'(bus.cfg_item) < N_ITEMS) && (int'(bus.cfg_field) <= N_DIMS)) begin
            coef_tab[bus.cfg_field][bus.cfg_item] <= bus.cfg_data;
        end
    end

    // Control FSM, Gray stepper and best-selection tracker
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            step          <= '0;
            cur_mask      <= '0;
            min_lat       <= '0;
            cost_lat      <= '0;
            found_r       <= 1'b0;
            best_mask_r   <= '0;
            best_value_r  <= '0;
            valid_count_r <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state         <= ST_SEARCH;
                        step          <= '0;
                        cur_mask      <= '0;
                        min_lat       <= bus.min_value;
                        cost_lat      <= bus.max_cost;
                        found_r       <= 1'b0;
                        best_mask_r   <= '0;
                        best_value_r  <= '0;
                        valid_count_r <= '0;
                    end
                end
                ST_SEARCH: begin
                    if (bus.abort) begin
                        state         <= ST_IDLE;
                        found_r       <= 1'b0;
                        best_mask_r   <= '0;
                        best_value_r  <= '0;
                        valid_count_r <= '0;
                    end else begin
                        if (cur_ok) begin
                            valid_count_r <= valid_count_r + CNT_W'(1);
                            // Strictly greater keeps the earliest selection on ties
                            if (!found_r || (sums[FIELD_VALUE] > best_value_r)) begin
                                found_r      <= 1'b1;
                                best_mask_r  <= cur_mask;
                                best_value_r <= sums[FIELD_VALUE];
                            end
                        end
                        if (last_step) begin
                            state <= ST_DONE;
                        end else begin
                            step     <= step_nxt;
                            cur_mask <= cur_mask ^ (N_ITEMS'(1) << flip_idx);
                        end
                    end
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy        = (state == ST_SEARCH);
    assign bus.done        = (state == ST_DONE);
    assign bus.found       = found_r;
    assign bus.best_mask   = best_mask_r;
    assign bus.best_value  = best_value_r;
    assign bus.valid_count = valid_count_r;

endmodule

// File: tb/tb_knap_multi_search.sv
// Directed bench for the knapsack solver: a 3-item instance with hand-computed results
// and a 10-item instance checked against a brute-force reference over random tables.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_knap_multi_search;
    import knap_pkg::*;

    localparam int NA = 3;
    localparam int NB = 10;
    localparam int ND = 2;
    localparam int CW = 9;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    knap_multi_search_if #(.N_ITEMS(NA), .N_DIMS(ND), .COEF_W(CW)) ifa ();
    knap_multi_search_if #(.N_ITEMS(NB), .N_DIMS(ND), .COEF_W(CW)) ifb ();

    knap_multi_search #(.N_ITEMS(NA), .N_DIMS(ND), .COEF_W(CW)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    knap_multi_search #(.N_ITEMS(NB), .N_DIMS(ND), .COEF_W(CW)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_res_a(input string tag, input int fnd, input int mask, input int val, input int cnt);
        chk({tag, "_found"}, 64'(ifa.found), 64'(fnd));
        chk({tag, "_mask"},  64'(ifa.best_mask), 64'(mask));
        chk({tag, "_value"}, 64'(ifa.best_value), 64'(val));
        chk({tag, "_count"}, 64'(ifa.valid_count), 64'(cnt));
    endtask

    task automatic wr_a(input int item, input int field, input int data);
        @(negedge clk);
        ifa.cfg_we    = 1'b1;
        ifa.cfg_item  = 2'(item);
        ifa.cfg_field = 2'(field);
        ifa.cfg_data  = 9'(data);
        @(negedge clk);
        ifa.cfg_we    = 1'b0;
    endtask

    task automatic item_a(input int item, input int v, input int w, input int u);
        wr_a(item, 0, v);
        wr_a(item, 1, w);
        wr_a(item, 2, u);
    endtask

    task automatic limits_a(input int minv, input int c0, input int c1);
        ifa.min_value = 9'(minv);
        ifa.max_cost  = {9'(c1), 9'(c0)};
    endtask

    // Start a search and wait (bounded) for done; lat = cycles from start cycle to done cycle.
    // blk_wr attempts a table write (item 2 value := 0) during SEARCH; abort_too raises abort with start.
    task automatic run_a(input bit blk_wr, input bit abort_too, output int lat);
        int t0;
        @(negedge clk);
        ifa.start = 1'b1;
        ifa.abort = abort_too;
        t0  = cyc;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            ifa.start  = 1'b0;
            ifa.abort  = 1'b0;
            ifa.cfg_we = 1'b0;
            if (blk_wr && n == 2) begin
                ifa.cfg_we    = 1'b1;
                ifa.cfg_item  = 2'd2;
                ifa.cfg_field = 2'd0;
                ifa.cfg_data  = 9'd0;
            end
            if (ifa.done === 1'b1) begin
                lat = cyc - t0;
                break;
            end
        end
        ifa.cfg_we = 1'b0;
    endtask

    task automatic load_sc1();
        item_a(0, 4, 28, 27);
        item_a(1, 8, 8, 27);
        item_a(2, 20, 18, 4);
    endtask

    int lat;
    int done_cnt;
    int t0;
    int vb [NB];
    int wb [NB];
    int ub [NB];
    int mv, mc0, mc1;
    int e_mask, e_val, e_cnt, e_fnd;

    initial begin
        rst_n = 1'b0;
        ifa.cfg_we = 1'b0; ifa.cfg_item = '0; ifa.cfg_field = '0; ifa.cfg_data = '0;
        ifa.min_value = '0; ifa.max_cost = '0; ifa.start = 1'b0; ifa.abort = 1'b0;
        ifb.cfg_we = 1'b0; ifb.cfg_item = '0; ifb.cfg_field = '0; ifb.cfg_data = '0;
        ifb.min_value = '0; ifb.max_cost = '0; ifb.start = 1'b0; ifb.abort = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy", 64'(ifa.busy), 64'd0);
        chk("rst_done", 64'(ifa.done), 64'd0);
        chk_res_a("rst", 0, 0, 0, 0);
        rst_n = 1'b1;

        // Cleared table with floor 0: every selection valid at value 0, first one (mask 0) wins
        limits_a(0, 60, 60);
        run_a(1'b0, 1'b0, lat);
        chk("clr_lat", 64'(lat), 64'd9);
        chk_res_a("clr", 1, 0, 0, 8);

        // Basic search: valid masks 100,101,110,111; best 111 at value 32
        load_sc1();
        limits_a(20, 60, 60);
        run_a(1'b0, 1'b0, lat);
        chk("sc1_lat", 64'(lat), 64'd9);
        chk("sc1_busy_at_done", 64'(ifa.busy), 64'd0);
        chk_res_a("sc1", 1, 7, 32, 4);
        repeat (3) @(negedge clk);
        chk("sc1_hold_done", 64'(ifa.done), 64'd0);
        chk_res_a("sc1_hold", 1, 7, 32, 4);

        // Unreachable floor: nothing valid, done still pulses
        limits_a(100, 60, 60);
        run_a(1'b0, 1'b0, lat);
        chk("sc2_lat", 64'(lat), 64'd9);
        chk_res_a("sc2", 0, 0, 0, 0);

        // Tie on value 10: 001 comes first in Gray order; abort alongside start must not block it
        item_a(0, 10, 40, 27);
        item_a(1, 10, 40, 27);
        item_a(2, 0, 0, 4);
        limits_a(10, 50, 60);
        run_a(1'b0, 1'b1, lat);
        chk("sc3_lat", 64'(lat), 64'd9);
        chk_res_a("sc3", 1, 1, 10, 4);

        // Abort in SEARCH cycle 4: masks 000,001,011 already counted with floor 0
        load_sc1();
        limits_a(0, 60, 60);
        @(negedge clk);
        ifa.start = 1'b1;
        t0 = cyc;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            ifa.start = 1'b0;
        end
        chk("ab_busy_pre", 64'(ifa.busy), 64'd1);
        chk("ab_count_pre", 64'(ifa.valid_count), 64'd3);
        chk("ab_value_pre", 64'(ifa.best_value), 64'd12);
        ifa.abort = 1'b1;
        @(negedge clk);
        ifa.abort = 1'b0;
        chk("ab_busy", 64'(ifa.busy), 64'd0);
        chk_res_a("ab", 0, 0, 0, 0);
        done_cnt = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (ifa.done === 1'b1) done_cnt++;
        end
        chk("ab_no_done", 64'(done_cnt), 64'd0);

        // Reset mid-search, then a reloaded table reproduces the basic result
        @(negedge clk);
        ifa.start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            ifa.start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mr_busy", 64'(ifa.busy), 64'd0);
        chk_res_a("mr", 0, 0, 0, 0);
        load_sc1();
        limits_a(20, 60, 60);
        run_a(1'b0, 1'b0, lat);
        chk("mr_lat", 64'(lat), 64'd9);
        chk_res_a("mr_rerun", 1, 7, 32, 4);

        // Table write during SEARCH is dropped
        run_a(1'b1, 1'b0, lat);
        chk("blk_lat", 64'(lat), 64'd9);
        chk_res_a("blk", 1, 7, 32, 4);

        // Same write while idle takes effect: item 2 worth 0, floor 10 -> 011 and 111 valid at 12
        wr_a(2, 0, 0);
        limits_a(10, 60, 60);
        run_a(1'b0, 1'b0, lat);
        chk("wr_lat", 64'(lat), 64'd9);
        chk_res_a("wr", 1, 3, 12, 2);

        // Random 10-item tables against a brute-force reference
        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < NB; i++) begin
                vb[i] = int'($urandom_range(0, 511));
                wb[i] = int'($urandom_range(0, 120));
                ub[i] = int'($urandom_range(0, 120));
            end
            mv  = (s == 0) ? 0 : int'($urandom_range(0, 400));
            mc0 = int'($urandom_range(100, 511));
            mc1 = int'($urandom_range(100, 511));
            for (int i = 0; i < NB; i++) begin
                for (int f = 0; f <= ND; f++) begin
                    @(negedge clk);
                    ifb.cfg_we    = 1'b1;
                    ifb.cfg_item  = 4'(i);
                    ifb.cfg_field = 2'(f);
                    ifb.cfg_data  = 9'((f == 0) ? vb[i] : (f == 1) ? wb[i] : ub[i]);
                end
            end
            @(negedge clk);
            ifb.cfg_we    = 1'b0;
            ifb.min_value = 9'(mv);
            ifb.max_cost  = {9'(mc1), 9'(mc0)};

            e_fnd = 0; e_mask = 0; e_val = 0; e_cnt = 0;
            for (int k = 0; k < (1 << NB); k++) begin
                int g, sv, sw, su;
                g = k ^ (k >> 1);
                sv = 0; sw = 0; su = 0;
                for (int i = 0; i < NB; i++) begin
                    if (g[i]) begin
                        sv += vb[i];
                        sw += wb[i];
                        su += ub[i];
                    end
                end
                if (sv >= mv && sw <= mc0 && su <= mc1) begin
                    e_cnt++;
                    if (e_fnd == 0 || sv > e_val) begin
                        e_fnd  = 1;
                        e_val  = sv;
                        e_mask = g;
                    end
                end
            end

            ifb.start = 1'b1;
            t0  = cyc;
            lat = -1;
            for (int n = 1; n <= 1100; n++) begin
                @(negedge clk);
                ifb.start = 1'b0;
                if (ifb.done === 1'b1) begin
                    lat = cyc - t0;
                    break;
                end
            end
            chk($sformatf("rnd%0d_lat", s),   64'(lat), 64'd1025);
            chk($sformatf("rnd%0d_found", s), 64'(ifb.found), 64'(e_fnd));
            chk($sformatf("rnd%0d_mask", s),  64'(ifb.best_mask), 64'(e_mask));
            chk($sformatf("rnd%0d_value", s), 64'(ifb.best_value), 64'(e_val));
            chk($sformatf("rnd%0d_count", s), 64'(ifb.valid_count), 64'(e_cnt));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
